// File: rtl/fc_relu_out_buffer.sv
// ---------------------------------------------------------------------------
// fc_relu_out_buffer
//
// Output stage for the fully-connected layer. Each accepted element gets
// ReLU followed by an arithmetic right shift by SHIFT. The result is tagged
// with an end-of-vector flag on every M-th element. It is then stored in a
// DEPTH-entry first-word-fall-through FIFO and re-emitted with valid/ready.
//
// Parameters
//   M      elements per output vector (>=1)
//   T      data width, signed two's complement
//   DEPTH  FIFO capacity in elements (>=2, need not be a power of 2)
//   SHIFT  right-shift applied after ReLU (0..T-1)
//
// Ports
//   clk           clock, all state on rising edge
//   reset         synchronous active-high reset
//   input_valid   upstream element valid
//   input_ready   space available (count < DEPTH)
//   input_data    signed element from the fc layer
//   output_valid  head element valid (count != 0)
//   output_ready  downstream accepts the head element
//   output_data   transformed head element, 0 when output_valid=0
//   output_last   end-of-vector flag of head element, 0 when output_valid=0
// ---------------------------------------------------------------------------
module fc_relu_out_buffer #(
   parameter int M     = 6,
   parameter int T     = 8,
   parameter int DEPTH = 8,
   parameter int SHIFT = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         input_valid,
   output logic         input_ready,
   input  logic [T-1:0] input_data,
   output logic         output_valid,
   input  logic         output_ready,
   output logic [T-1:0] output_data,
   output logic         output_last
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (M > 1) ? $clog2(M) : 1;

   localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [IW-1:0] IDX_LAST   = IW'(M - 1);

   // Each entry is {last, y}
   logic [T:0]          mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [IW-1:0]       in_idx_q, in_idx_d;

   logic                push;
   logic                pop;
   logic signed [T-1:0] x_s;
   logic signed [T-1:0] shifted;
   logic [T-1:0]        relu_y;
   logic                last_in;
   logic [T:0]          head;

   // Handshake flags depend only on the occupancy register, so there is no
   // combinational path from output_ready to input_ready.
   assign input_ready  = (count_q < COUNT_FULL);
   assign output_valid = (count_q != '0);
   assign push         = input_valid && input_ready;
   assign pop          = output_valid && output_ready;

   // ReLU first, then shift: a non-negative value shifted right can never
   // go negative or overflow, so the result stays in T bits.
   assign x_s     = input_data;
   assign shifted = x_s >>> SHIFT;
   assign relu_y  = x_s[T-1] ? '0 : shifted;
   assign last_in = (in_idx_q == IDX_LAST);

   // First-word-fall-through head; gated to zero when the FIFO is empty
   assign head        = mem_q[rd_ptr_q];
   assign output_data = output_valid ? head[T-1:0] : '0;
   assign output_last = output_valid ? head[T] : 1'b0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      in_idx_d = in_idx_q;

      // Explicit wrap compares keep non-power-of-2 depths correct
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         in_idx_d = last_in ? '0 : in_idx_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         in_idx_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         in_idx_q <= in_idx_d;
      end
   end

   // Storage needs no reset: an empty FIFO never exposes an entry
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= {last_in, relu_y};
      end
   end

endmodule

// File: tb/tb_fc_relu_out_buffer.sv
module tb_fc_relu_out_buffer;

   localparam int M  = 6;
   localparam int DA = 8;
   localparam int SA = 0;
   localparam int DB = 6;
   localparam int SB = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_iv, a_ir, a_ov, a_or, a_ol;
   logic [7:0] a_id, a_od;
   logic       b_iv, b_ir, b_ov, b_or, b_ol;
   logic [7:0] b_id, b_od;

   always #5 clk = ~clk;

   fc_relu_out_buffer #(.M(M), .T(8), .DEPTH(DA), .SHIFT(SA)) dut_a (
      .clk(clk), .reset(reset),
      .input_valid(a_iv), .input_ready(a_ir), .input_data(a_id),
      .output_valid(a_ov), .output_ready(a_or),
      .output_data(a_od), .output_last(a_ol)
   );

   fc_relu_out_buffer #(.M(M), .T(8), .DEPTH(DB), .SHIFT(SB)) dut_b (
      .clk(clk), .reset(reset),
      .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id),
      .output_valid(b_ov), .output_ready(b_or),
      .output_data(b_od), .output_last(b_ol)
   );

   typedef struct { int y; bit last; } item_t;
   typedef struct { int x; int y; bit last; } vec_t;

   item_t qa[$];
   item_t qb[$];
   int    ia = 0, ib = 0;
   bit    a_pop_last[$];
   int    a_pop_cnt = 0, b_pop_cnt = 0;
   int    n_checks = 0, n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int relu(input int x, input int sh);
      if (x < 0) return 0;
      return x / (1 << sh);
   endfunction

   // One clock: compare both DUTs against the queue models, then advance.
   task automatic cycle();
      bit    ap, aq, bp, bq;
      int    xa, xb;
      item_t it;
      check("a_valid", a_ov, qa.size() != 0);
      check("a_ready", a_ir, qa.size() < DA);
      if (qa.size() != 0) begin
         check("a_data", a_od, qa[0].y);
         check("a_last", a_ol, qa[0].last);
      end else begin
         check("a_data_idle", a_od, 0);
         check("a_last_idle", a_ol, 0);
      end
      check("b_valid", b_ov, qb.size() != 0);
      check("b_ready", b_ir, qb.size() < DB);
      if (qb.size() != 0) begin
         check("b_data", b_od, qb[0].y);
         check("b_last", b_ol, qb[0].last);
      end else begin
         check("b_data_idle", b_od, 0);
         check("b_last_idle", b_ol, 0);
      end
      ap = a_iv && (qa.size() < DA);
      aq = a_or && (qa.size() != 0);
      bp = b_iv && (qb.size() < DB);
      bq = b_or && (qb.size() != 0);
      xa = $signed(a_id);
      xb = $signed(b_id);
      if (!reset && aq) a_pop_last.push_back(a_ol);
      @(posedge clk);
      #1;
      if (reset) begin
         qa.delete();
         qb.delete();
         ia = 0;
         ib = 0;
      end else begin
         if (aq) begin void'(qa.pop_front()); a_pop_cnt++; end
         if (ap) begin
            it.y = relu(xa, SA); it.last = (ia == M - 1);
            ia = (ia + 1) % M;
            qa.push_back(it);
         end
         if (bq) begin void'(qb.pop_front()); b_pop_cnt++; end
         if (bp) begin
            it.y = relu(xb, SB); it.last = (ib == M - 1);
            ib = (ib + 1) % M;
            qb.push_back(it);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_iv = 1'b0;
      b_iv = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t pt[6];
      vec_t sh[4];
      int   acc, p0, pushed;

      pt[0] = '{5, 5, 1'b0};
      pt[1] = '{-3, 0, 1'b0};
      pt[2] = '{0, 0, 1'b0};
      pt[3] = '{127, 127, 1'b0};
      pt[4] = '{-128, 0, 1'b0};
      pt[5] = '{7, 7, 1'b1};
      sh[0] = '{13, 3, 1'b0};
      sh[1] = '{-1, 0, 1'b0};
      sh[2] = '{127, 31, 1'b0};
      sh[3] = '{3, 0, 1'b0};

      reset = 1'b1;
      a_iv = 0; a_id = 0; a_or = 0;
      b_iv = 0; b_id = 0; b_or = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_a_ready", a_ir, 1);
      check("rst_a_valid", a_ov, 0);
      check("rst_a_data", a_od, 0);
      check("rst_a_last", a_ol, 0);
      check("rst_b_ready", b_ir, 1);
      check("rst_b_valid", b_ov, 0);

      // Pass-through, one element per cycle, output one cycle after push
      a_or = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_iv = 1'b1;
         a_id = 8'(pt[i].x);
         cycle();
         check($sformatf("pt_valid[%0d]", i), a_ov, 1);
         check($sformatf("pt_data[%0d]", i), a_od, pt[i].y);
         check($sformatf("pt_last[%0d]", i), a_ol, pt[i].last);
      end
      a_iv = 1'b0;
      cycle();
      check("pt_empty", a_ov, 0);

      // Shift by 2 on the second instance
      b_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_iv = 1'b1;
         b_id = 8'(sh[i].x);
         cycle();
         check($sformatf("sh_data[%0d]", i), b_od, sh[i].y);
         check($sformatf("sh_last[%0d]", i), b_ol, sh[i].last);
      end
      b_iv = 1'b0;
      cycle();

      // Fill to capacity with output stalled, then drain
      do_reset();
      a_or = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         a_iv = 1'b1;
         a_id = 8'($urandom);
         if (a_ir) acc++;
         cycle();
      end
      check("full_accepted", acc, 8);
      check("full_ready_low", a_ir, 0);
      a_or = 1'b1;
      p0 = a_pop_cnt;
      for (int k = 0; k < 40 && (qa.size() != 0 || acc < 10); k++) begin
         a_iv = (acc < 10);
         a_id = 8'($urandom);
         if (a_iv && a_ir) acc++;
         cycle();
         if (k == 7) check("full_nogap", a_pop_cnt - p0, 8);
      end
      a_iv = 1'b0;
      check("full_total_acc", acc, 10);
      check("full_total_pop", a_pop_cnt - p0, 10);
      check("full_empty", a_ov, 0);

      // Steady simultaneous push/pop at occupancy 3, DEPTH=6 wraps pointers
      do_reset();
      b_or = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_iv = 1'b1;
         b_id = 8'($urandom);
         cycle();
      end
      b_or = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b_iv = 1'b1;
         b_id = 8'($urandom);
         check("pp_both", b_ir && b_ov, 1);
         cycle();
      end
      b_iv = 1'b0;
      p0 = b_pop_cnt;
      for (int i = 0; i < 3; i++) cycle();
      check("pp_drain_pops", b_pop_cnt - p0, 3);
      check("pp_drained", b_ov, 0);

      // Framing across three vectors with random stalls
      do_reset();
      a_pop_last.delete();
      pushed = 0;
      for (int k = 0; k < 600 && a_pop_last.size() < 18; k++) begin
         a_iv = (pushed < 18) && ($urandom_range(0, 1) == 1);
         a_or = ($urandom_range(0, 2) != 0);
         a_id = 8'($urandom);
         if (a_iv && a_ir) pushed++;
         cycle();
      end
      a_iv = 1'b0;
      check("frame_pops", a_pop_last.size(), 18);
      for (int n = 0; n < a_pop_last.size(); n++)
         check($sformatf("frame_last[%0d]", n + 1), a_pop_last[n], ((n + 1) % M) == 0);

      // Reset in the middle of a vector
      do_reset();
      a_or = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_iv = 1'b1;
         a_id = 8'($urandom);
         cycle();
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      a_iv = 1'b0;
      check("midrst_valid", a_ov, 0);
      check("midrst_ready", a_ir, 1);
      a_pop_last.delete();
      a_or = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_iv = 1'b1;
         a_id = 8'($urandom);
         cycle();
      end
      a_iv = 1'b0;
      for (int k = 0; k < 10 && qa.size() != 0; k++) cycle();
      check("midrst_pops", a_pop_last.size(), 6);
      for (int n = 0; n < a_pop_last.size(); n++)
         check($sformatf("midrst_last[%0d]", n + 1), a_pop_last[n], n == 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fc_relu_out_buffer.md
# fc_relu_out_buffer

Downstream stage for the fully-connected layer block. Consumes the layer's serial stream of signed T-bit dot-product results and applies ReLU plus an arithmetic right shift. Buffers the results in a small first-word-fall-through FIFO and re-emits them with a valid/ready handshake. Each emitted element carries an end-of-vector flag, so the next layer can frame the M-element output vector.

## Interface
- M, 6, output vector length (elements per frame), ≥1
- T, 8, data width in bits, signed two's complement
- DEPTH, 8, FIFO capacity in elements, ≥2
- SHIFT, 0, right-shift amount applied after ReLU, 0..T-1
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- input_valid  input  1  upstream element valid
- input_ready  output  1  block can accept an element this cycle
- input_data  input  T  signed element from the fc layer
- output_valid  output  1  output_data/output_last hold a valid element
- output_ready  input  1  downstream accepts the element this cycle
- output_data  output  T  signed result, always ≥0
- output_last  output  1  high on the M-th element of each vector

## Operation
- A push occurs on a rising edge where input_valid && input_ready. A pop occurs on a rising edge where output_valid && output_ready.
- Transform on push: y = (x < 0) ? 0 : (x >>> SHIFT). Result width stays T. The result is never negative and never saturates.
- Storage: DEPTH entries, each holding {last, y[T-1:0]}.
  - Write pointer and read pointer wrap from DEPTH-1 to 0. This must hold for DEPTH values that are not a power of 2.
  - Occupancy counter `count` runs 0..DEPTH.
- Framing: `in_idx` counts pushes 0..M-1. The stored last bit is (in_idx == M-1). On that push, in_idx wraps to 0. With M=1, every element has last=1.
- input_ready = (count < DEPTH), combinational from registered state. It does not depend on output_ready, so there is no pass-through when the FIFO is full.
- output_valid = (count != 0).
- output_data and output_last come from the entry at the read pointer (FWFT). When output_valid=0, both are forced to 0.
- Push and pop in the same cycle:
  - count is unchanged and both pointers advance.
  - This is legal only when 0 < count < DEPTH, because at count=0 there is no pop and at count=DEPTH there is no push.
- Holding rules:
  - If output_valid=1 and output_ready=0, output_data and output_last hold stable.
  - A push while output_valid=1 does not change the current head element.
- Reset forces these values on the next edge regardless of in-flight traffic:
  - count=0 and both pointers =0
  - in_idx=0
  - buffered data is discarded
  - A vector interrupted mid-frame restarts at index 0 after reset.

## Timing
- Reset values of outputs: input_ready=1, output_valid=0, output_data=0, output_last=0.
- Latency: an element pushed at edge k into an empty FIFO appears with output_valid=1 in the cycle after edge k, and can pop at edge k+1.
- Throughput: one element per cycle sustained when output_ready is held high.
- Back-pressure: after DEPTH pushes without a pop, input_ready drops in the cycle following the DEPTH-th push. It rises again the cycle after the first pop.
- input_data is ignored while input_ready=0 or input_valid=0. Neither in_idx nor any pointer moves.
- All outputs are functions of registered state only. There is no combinational path from input_* to output_* or from output_ready to input_ready.

## Test plan
- Reset and pass-through, T=8, SHIFT=0, M=6, output_ready=1:
  - Stimulus: push 5, -3, 0, 127, -128, 7.
  - Required output, one per cycle starting 1 cycle after the first push: 5, 0, 0, 127, 0, 7.
  - output_last=1 only on the 7.
- Shift, SHIFT=2:
  - Stimulus: push 13, -1, 127, 3.
  - Required output: 3, 0, 31, 0.
- Full and back-pressure, DEPTH=8, output_ready=0:
  - Stimulus: push 10 elements with input_valid held high.
  - Required: exactly 8 are accepted and input_ready=0 after the 8th.
  - Then raise output_ready. Required: the 8 elements drain in order with no gaps, the remaining 2 are accepted, and no element is lost or duplicated.
- Simultaneous push/pop at count=3 for 20 cycles:
  - Required: count stays 3 and the data order is preserved.
  - Pointers wrap correctly with DEPTH=6 (non-power-of-2 build).
- Framing across vectors, M=6:
  - Stimulus: push 18 elements with random valid/ready stalls.
  - Required: output_last on emitted elements 6, 12 and 18 only.
- Reset mid-frame:
  - Stimulus: after 3 pushes of a vector (FIFO non-empty), assert reset for 1 cycle.
  - Required next cycle: output_valid=0, input_ready=1.
  - Then push 6 elements. Required: output_last is on the 6th element.
